led_blink_sw_top: RTL and testbench

Top-level LED demo block for the Trion T120 board. It drives eight user LEDs with selectable blink patterns from one oscillator clock. The four DIP switches select the pattern and its speed. The four push switches pause, reverse, invert or restart the pattern.

---
 rtl/led_blink_sw_top.sv | 157 +++++++++++++++
 tb/tb_led_blink_sw_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_sw_top.sv
// LED pattern demo top: synchronised DIP/push switches, debounced pushes,
// a prescaled step tick and a pattern register driving eight user LEDs.
module led_blink_sw_top #(
    parameter int unsigned pBaseDiv  = 5_000_000,
    parameter int unsigned pDbCycles = 500_000
) (
    input  logic       iOscClk,
    input  logic       iRst,
    input  logic [3:0] iUserDipSw,
    input  logic [3:0] iUserPushSw,
    output logic [7:0] oUserLed
);

    localparam int unsigned PRE_W = $clog2(pBaseDiv);
    localparam int unsigned DB_W  = $clog2(pDbCycles);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(pBaseDiv - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(pDbCycles - 1);

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_ECHO   = 2'b11
    } mode_e;

    logic [3:0]       dip_meta_q,  dip_meta_d;
    logic [3:0]       dip_sync_q,  dip_sync_d;
    logic [3:0]       push_meta_q, push_meta_d;
    logic [3:0]       push_sync_q, push_sync_d;
    logic [DB_W-1:0]  db_cnt_q [4];
    logic [DB_W-1:0]  db_cnt_d [4];
    logic [3:0]       db_q,        db_d;
    logic [1:0]       db_prev_q,   db_prev_d;   // {restart, reverse} one cycle ago
    logic [PRE_W-1:0] pre_cnt_q,   pre_cnt_d;
    logic [2:0]       tick_cnt_q,  tick_cnt_d;
    logic             dir_q,       dir_d;
    mode_e            mode_prev_q, mode_prev_d;
    logic [7:0]       pattern_q,   pattern_d;
    logic [7:0]       led_q,       led_d;

    mode_e      mode_cur;
    logic       base_tick;
    logic       step_tick;
    logic [2:0] speed_mask;
    logic       reverse_rise;
    logic       restart_rise;

    assign mode_cur = mode_e'(dip_sync_q[1:0]);
    assign oUserLed = led_q;

    // Two-stage synchronisers for both switch banks
    always_comb begin
        dip_meta_d  = iUserDipSw;
        dip_sync_d  = dip_meta_q;
        push_meta_d = iUserPushSw;
        push_sync_d = push_meta_q;
    end

    // Per-bit debounce: accept a new value after pDbCycles consecutive differing cycles
    always_comb begin
        db_d = db_q;
        for (int unsigned i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (push_sync_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = push_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        db_prev_d    = {db_q[3], db_q[1]};
        reverse_rise = db_q[1] & ~db_prev_q[0];
        restart_rise = db_q[3] & ~db_prev_q[1];
    end

    // Free-running prescaler and tick counter producing the step tick
    always_comb begin
        base_tick  = (pre_cnt_q == PRE_LAST);
        pre_cnt_d  = base_tick ? '0 : pre_cnt_q + 1'b1;
        tick_cnt_d = tick_cnt_q + {2'b00, base_tick};
        case (dip_sync_q[3:2])
            2'd0:    speed_mask = 3'b000;
            2'd1:    speed_mask = 3'b001;
            2'd2:    speed_mask = 3'b011;
            default: speed_mask = 3'b111;
        endcase
        // Step fires when the low n bits are all ones, so speed changes
        // never need to clear the tick counter.
        step_tick = base_tick && ((tick_cnt_q & speed_mask) == speed_mask);
    end

    // Pattern, direction and LED output selection
    always_comb begin
        pattern_d   = pattern_q;
        dir_d       = dir_q ^ reverse_rise;
        mode_prev_d = mode_cur;
        if (mode_cur != MODE_ECHO) begin
            if (mode_cur != mode_prev_q) begin
                pattern_d = (mode_cur == MODE_ROTATE) ? 8'h01 : 8'h00;
            end else if (restart_rise) begin
                pattern_d = (mode_cur == MODE_ROTATE) ? 8'h01 : 8'h00;
            end else if (step_tick && !db_q[0]) begin
                case (mode_cur)
                    MODE_COUNT:  pattern_d = dir_q ? pattern_q - 8'd1 : pattern_q + 8'd1;
                    MODE_ROTATE: pattern_d = dir_q ? {pattern_q[0], pattern_q[7:1]}
                                                   : {pattern_q[6:0], pattern_q[7]};
                    MODE_BLINK:  pattern_d = ~pattern_q;
                    default:     pattern_d = pattern_q;
                endcase
            end
        end
        if (mode_cur == MODE_ECHO) begin
            led_d = {dip_sync_q, db_q};
        end else begin
            led_d = pattern_q ^ {8{db_q[2]}};
        end
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge iOscClk or posedge iRst) begin
        if (iRst) begin
            dip_meta_q  <= '0;
            dip_sync_q  <= '0;
            push_meta_q <= '0;
            push_sync_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            db_q        <= '0;
            db_prev_q   <= '0;
            pre_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            dir_q       <= 1'b0;
            mode_prev_q <= MODE_COUNT;
            pattern_q   <= '0;
            led_q       <= '0;
        end else begin
            dip_meta_q  <= dip_meta_d;
            dip_sync_q  <= dip_sync_d;
            push_meta_q <= push_meta_d;
            push_sync_q <= push_sync_d;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            pre_cnt_q   <= pre_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            dir_q       <= dir_d;
            mode_prev_q <= mode_prev_d;
            pattern_q   <= pattern_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: tb/tb_led_blink_sw_top.sv
// Bench for led_blink_sw_top: directed vector table, hand sequences and
// randomized switch activity against a behavioural model.
module tb_led_blink_sw_top;

    localparam int unsigned D  = 4;
    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dip = 4'h0;
    logic [3:0] push = 4'h0;
    logic [7:0] led;
    logic [7:0] led_def;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_blink_sw_top #(.pBaseDiv(D), .pDbCycles(DB)) dut (
        .iOscClk    (clk),
        .iRst       (rst),
        .iUserDipSw (dip),
        .iUserPushSw(push),
        .oUserLed   (led)
    );

    led_blink_sw_top dut_def (
        .iOscClk    (clk),
        .iRst       (rst),
        .iUserDipSw (dip),
        .iUserPushSw(push),
        .oUserLed   (led_def)
    );

    // ---------------- behavioural reference model ----------------
    int unsigned m_k;
    logic [3:0]  m_sdip, m_spush, m_db;
    logic        m_rev_prev, m_rs_prev;
    logic [1:0]  m_mode_prev;
    int unsigned m_pat;
    logic        m_dir;
    logic [7:0]  m_led;
    logic [3:0]  dq[$];
    logic [3:0]  pq[$];
    logic [3:0]  sp_hist[$];

    task automatic model_reset();
        m_k = 0;
        m_sdip = 4'h0; m_spush = 4'h0; m_db = 4'h0;
        m_rev_prev = 1'b0; m_rs_prev = 1'b0;
        m_mode_prev = 2'd0; m_pat = 0; m_dir = 1'b0; m_led = 8'h00;
        dq.delete(); pq.delete(); sp_hist.delete();
        dq.push_back(4'h0);
        pq.push_back(4'h0);
    endtask

    task automatic model_edge();
        logic [3:0]  sd, sp, ndb;
        logic [1:0]  mode;
        int unsigned n, np, init;
        logic        rev, rs, stp, all_diff;
        if (rst) return;
        m_k++;
        sd   = m_sdip;
        sp   = m_spush;
        mode = sd[1:0];
        n    = sd[3:2];
        rev  = m_db[1] && !m_rev_prev;
        rs   = m_db[3] && !m_rs_prev;
        stp  = (m_k % (D << n)) == 0;
        init = (mode == 2'd1) ? 1 : 0;
        np   = m_pat;
        if (mode != 2'd3) begin
            if (mode != m_mode_prev)       np = init;
            else if (rs)                   np = init;
            else if (stp && !m_db[0]) begin
                case (mode)
                    2'd0:    np = m_dir ? (m_pat + 255) % 256 : (m_pat + 1) % 256;
                    2'd1:    np = m_dir ? ((m_pat >> 1) | (m_pat << 7)) & 255
                                        : ((m_pat << 1) | (m_pat >> 7)) & 255;
                    default: np = m_pat ^ 255;
                endcase
            end
        end
        if (mode == 2'd3) m_led = {sd, m_db};
        else              m_led = 8'(m_pat) ^ {8{m_db[2]}};
        // a debounced bit flips once the last DB synced samples all disagree with it
        sp_hist.push_back(sp);
        if (sp_hist.size() > int'(DB)) void'(sp_hist.pop_front());
        ndb = m_db;
        for (int b = 0; b < 4; b++) begin
            all_diff = (sp_hist.size() == int'(DB));
            foreach (sp_hist[j]) if (sp_hist[j][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) ndb[b] = ~m_db[b];
        end
        dq.push_back(dip);
        pq.push_back(push);
        m_sdip  = dq.pop_front();
        m_spush = pq.pop_front();
        m_rev_prev  = m_db[1];
        m_rs_prev   = m_db[3];
        m_db        = ndb;
        m_mode_prev = mode;
        m_pat       = np;
        m_dir       = m_dir ^ rev;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: update model at the edge, compare on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #5;
        check("model", led, m_led);
    endtask

    task automatic do_reset(input logic [3:0] d, input logic [3:0] p);
        dip = d;
        push = p;
        rst = 1'b1;
        model_reset();
        #1;
        check("reset_led", led, 8'h00);
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          rs;
        logic [3:0]  dip;
        logic [3:0]  push;
        int unsigned n;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rs, logic [3:0] d, logic [3:0] p, int unsigned n, logic [7:0] e);
        vec_t v;
        v.rs = rs; v.dip = d; v.push = p; v.n = n; v.exp = e;
        return v;
    endfunction

    initial begin
        // counter mode, speed 0: 0x01,0x02,0x03 then wrap 0xFF->0x00
        tbl.push_back(mk(1, 4'b0000, 4'b0000,    5, 8'h01));
        tbl.push_back(mk(0, 4'b0000, 4'b0000,    4, 8'h02));
        tbl.push_back(mk(0, 4'b0000, 4'b0000,    4, 8'h03));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1008, 8'hFF));
        tbl.push_back(mk(0, 4'b0000, 4'b0000,    4, 8'h00));
        // rotate, speed 1, then reverse press
        tbl.push_back(mk(1, 4'b0101, 4'b0000,    4, 8'h01));
        tbl.push_back(mk(0, 4'b0101, 4'b0000,    5, 8'h02));
        tbl.push_back(mk(0, 4'b0101, 4'b0000,    8, 8'h04));
        tbl.push_back(mk(0, 4'b0101, 4'b0010,   32, 8'h01));
        tbl.push_back(mk(0, 4'b0101, 4'b0010,    8, 8'h80));
        // blink with pause, invert, release
        tbl.push_back(mk(1, 4'b0010, 4'b0000,    5, 8'hFF));
        tbl.push_back(mk(0, 4'b0010, 4'b0001,   20, 8'h00));
        tbl.push_back(mk(0, 4'b0010, 4'b0001,    7, 8'h00));
        tbl.push_back(mk(0, 4'b0010, 4'b0101,   10, 8'hFF));
        tbl.push_back(mk(0, 4'b0010, 4'b0000,   11, 8'hFF));
        tbl.push_back(mk(0, 4'b0010, 4'b0000,    4, 8'h00));
        // restart: short pulse ignored, long hold at 0x25 reloads
        tbl.push_back(mk(1, 4'b0000, 4'b0000,  140, 8'h22));
        tbl.push_back(mk(0, 4'b0000, 4'b1000,    3, 8'h23));
        tbl.push_back(mk(0, 4'b0000, 4'b0000,    6, 8'h25));
        tbl.push_back(mk(0, 4'b0000, 4'b1000,   10, 8'h00));
        tbl.push_back(mk(0, 4'b0000, 4'b0000,    2, 8'h01));
        tbl.push_back(mk(0, 4'b0000, 4'b0000,    4, 8'h02));
        // echo mode, then switch to rotate
        tbl.push_back(mk(1, 4'b1011, 4'b0101,   10, 8'hB5));
        tbl.push_back(mk(0, 4'b1011, 4'b0000,   10, 8'hB0));
        tbl.push_back(mk(0, 4'b1001, 4'b0000,    4, 8'h01));

        // default-parameter instance idles dark with all switches off
        do_reset(4'h0, 4'h0);
        repeat (8000) begin
            cyc();
            check("default_idle", led_def, 8'h00);
        end

        // vector table
        foreach (tbl[i]) begin
            if (tbl[i].rs) begin
                do_reset(tbl[i].dip, tbl[i].push);
            end else begin
                dip  = tbl[i].dip;
                push = tbl[i].push;
            end
            repeat (tbl[i].n) cyc();
            check($sformatf("vec%0d", i), led, tbl[i].exp);
        end

        // asynchronous reset in the middle of counting
        do_reset(4'h0, 4'h0);
        repeat (30) cyc();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset", led, 8'h00);
        repeat (2) cyc();
        rst = 1'b0;
        repeat (9) cyc();
        check("post_reset_count", led, 8'h02);

        // randomized switch activity
        do_reset(4'($urandom), 4'h0);
        repeat (60) begin
            dip = 4'($urandom);
            if ($urandom_range(0, 2) == 0) push = 4'($urandom);
            repeat ($urandom_range(1, 40)) cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
